// File: rtl/dm_param.sv
// dm_param: parametrised synchronous data memory with byte-enable writes,
// a registered write-first read port, a req/ready handshake and a
// hardware zero-fill engine that clears the array after reset and on
// every clear pulse.
module dm_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     win,
    input  logic [DATA_W/8-1:0]   wbyte_enable,
    input  logic                  clear,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     dout
);

    localparam int NBYTE = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   clr_ptr_r;
    logic [ADDR_W-1:0]   clr_ptr_nxt_s;
    logic                ready_r;
    logic                rvalid_r;
    logic [DATA_W-1:0]   dout_r;
    logic                accept_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic [DATA_W-1:0]   merged_s;

    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Replace the enabled byte lanes of old_w with those of new_w.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NBYTE-1:0]  be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NBYTE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Request acceptance and the write-first merged word.
    always_comb begin
        accept_s  = req & ready_r & ~clear & (state_r == ST_IDLE);
        rd_word_s = mem_r[addr];
        merged_s  = merge_lanes(rd_word_s, win, wbyte_enable);
    end

    // Next-state logic: sweep the array in CLEAR, serve accesses in IDLE.
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        case (state_r)
            ST_CLEAR: begin
                clr_ptr_nxt_s = clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (clr_ptr_r == {ADDR_W{1'b1}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_ptr_nxt_s = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                    clr_ptr_nxt_s = clr_ptr_r;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_ptr_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, sweep pointer and registered handshake/data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {ADDR_W{1'b0}};
            ready_r   <= 1'b0;
            rvalid_r  <= 1'b0;
            dout_r    <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
            ready_r   <= (state_nxt_s == ST_IDLE);
            rvalid_r  <= accept_s & ~we;
            if (accept_s) begin
                dout_r <= we ? merged_s : rd_word_s;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    // RAM array: zero-fill during the sweep, otherwise merged writes.
    // A write with no lanes enabled rewrites the current word unchanged.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_ptr_r] <= {DATA_W{1'b0}};
        end else if (accept_s && we) begin
            mem_r[addr] <= merged_s;
        end
    end

    assign ready  = ready_r;
    assign rvalid = rvalid_r;
    assign dout   = dout_r;

endmodule

// File: tb/tb_dm_param.sv
// Bench for dm_param: directed accesses with hand-computed expectations;
// expected read data goes into a queue, and a monitor compares it whenever
// rvalid is presented.
module tb_dm_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Instance A: 32-bit words, 16 entries
    logic        req = 1'b0, we = 1'b0, clear = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] win = 32'd0;
    logic [3:0]  be = 4'd0;
    logic        ready, rvalid;
    logic [31:0] dout;

    // Instance B: 64-bit words, 8 entries
    logic        reqb = 1'b0, web = 1'b0, clearb = 1'b0;
    logic [2:0]  addrb = 3'd0;
    logic [63:0] winb = 64'd0;
    logic [7:0]  beb = 8'd0;
    logic        readyb, rvalidb;
    logic [63:0] doutb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] qa[$];
    logic [63:0] qb[$];

    dm_param #(.DATA_W(32), .ADDR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .win(win), .wbyte_enable(be), .clear(clear),
        .ready(ready), .rvalid(rvalid), .dout(dout)
    );

    dm_param #(.DATA_W(64), .ADDR_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(reqb), .we(web), .addr(addrb),
        .win(winb), .wbyte_enable(beb), .clear(clearb),
        .ready(readyb), .rvalid(rvalidb), .dout(doutb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor A: compare read data against the queue on each rvalid.
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rvalid_a_unexpected: got rvalid=1 dout=%h, expected no rvalid", dout);
            end else begin
                chk("rdata_a", {32'd0, dout}, {32'd0, qa.pop_front()});
            end
        end
    end

    // Monitor B: same for the 64-bit instance.
    always @(negedge clk) begin
        if (rst_n && rvalidb) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rvalid_b_unexpected: got rvalid=1 dout=%h, expected no rvalid", doutb);
            end else begin
                chk("rdata_b", doutb, qb.pop_front());
            end
        end
    end

    // One access on instance A; reads queue exp, writes check dout right after the edge.
    task automatic acc_a(input logic w, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] bev, input logic clr, input logic [31:0] exp);
        req = 1'b1; we = w; addr = a; win = d; be = bev; clear = clr;
        if (!w && !clr) qa.push_back(exp);
        @(posedge clk);
        #1;
        if (clr) begin
            chk("clear_dout_hold", {32'd0, dout}, {32'd0, exp});
            chk("clear_ready_low", {63'd0, ready}, 64'd0);
        end else if (w) begin
            chk("write_dout", {32'd0, dout}, {32'd0, exp});
            chk("write_rvalid", {63'd0, rvalid}, 64'd0);
        end
        req = 1'b0; we = 1'b0; clear = 1'b0; be = 4'd0;
    endtask

    task automatic acc_b(input logic w, input logic [2:0] a, input logic [63:0] d,
                         input logic [7:0] bev, input logic [63:0] exp);
        reqb = 1'b1; web = w; addrb = a; winb = d; beb = bev;
        if (!w) qb.push_back(exp);
        @(posedge clk);
        #1;
        if (w) chk("write_dout_b", doutb, exp);
        reqb = 1'b0; web = 1'b0; beb = 8'd0;
    endtask

    // Count negedges with ready low, bounded.
    task automatic wait_ready(input string name, input int exp_n);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (ready) break;
            n++;
        end
        chk(name, 64'(n), 64'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_rvalid", {63'd0, rvalid}, 64'd0);
        chk("reset_dout", {32'd0, dout}, 64'd0);
        rst_n = 1'b1;

        // 1) zero-fill after reset, then every word reads 0
        wait_ready("reset_clear_cycles", 16);
        for (int i = 0; i < 16; i++) acc_a(1'b0, 4'(i), 32'd0, 4'd0, 1'b0, 32'd0);

        // 2) byte-enable merge
        acc_a(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0, 32'hAABBCCDD);
        acc_a(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 32'hAA22CC44);
        acc_a(1'b0, 4'd3, 32'd0, 4'd0, 1'b0, 32'hAA22CC44);

        // 3) write then immediate read
        acc_a(1'b1, 4'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 32'hDEADBEEF);
        acc_a(1'b0, 4'd5, 32'd0, 4'd0, 1'b0, 32'hDEADBEEF);

        // write with no lanes: RAM unchanged, dout shows current word
        acc_a(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'hAA22CC44);
        acc_a(1'b0, 4'd3, 32'd0, 4'd0, 1'b0, 32'hAA22CC44);
        acc_a(1'b1, 4'd15, 32'h0000FFFF, 4'b0011, 1'b0, 32'h0000FFFF);
        acc_a(1'b0, 4'd15, 32'd0, 4'd0, 1'b0, 32'h0000FFFF);

        // 4) clear with simultaneous read: read dropped, dout holds
        acc_a(1'b0, 4'd3, 32'd0, 4'd0, 1'b1, 32'h0000FFFF);
        wait_ready("clear_cycles", 16);
        acc_a(1'b0, 4'd3, 32'd0, 4'd0, 1'b0, 32'd0);
        acc_a(1'b0, 4'd5, 32'd0, 4'd0, 1'b0, 32'd0);

        // 5) reset in the middle of a clear
        acc_a(1'b1, 4'd3, 32'h12345678, 4'b1111, 1'b0, 32'h12345678);
        acc_a(1'b1, 4'd14, 32'hCAFEF00D, 4'b1111, 1'b0, 32'hCAFEF00D);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("midclear_reset_cycles", 16);
        acc_a(1'b0, 4'd3, 32'd0, 4'd0, 1'b0, 32'd0);
        acc_a(1'b0, 4'd14, 32'd0, 4'd0, 1'b0, 32'd0);

        // 6) 64-bit instance: top-lane-only write
        chk("b_ready", {63'd0, readyb}, 64'd1);
        acc_b(1'b1, 3'd7, 64'hFF00_0000_0000_0000, 8'h80, 64'hFF00_0000_0000_0000);
        acc_b(1'b0, 3'd7, 64'd0, 8'h00, 64'hFF00_0000_0000_0000);
        acc_b(1'b1, 3'd7, 64'h0123_4567_89AB_CDEF, 8'h0F, 64'hFF00_0000_89AB_CDEF);
        acc_b(1'b0, 3'd7, 64'd0, 8'h00, 64'hFF00_0000_89AB_CDEF);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_a_drained", 64'(qa.size()), 64'd0);
        chk("queue_b_drained", 64'(qb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
